// File: rtl/legv8_multicycle_ctrl_if.sv
// Control and memory-handshake bundle between the LEGv8 multicycle sequencer and its datapath.
interface legv8_multicycle_ctrl_if;
    logic [10:0] opcode;
    logic        zero;
    logic        mem_ready;
    logic        mem_rd;
    logic        mem_wr;
    logic        addr_sel;
    logic        ir_wr;
    logic        pc_wr;
    logic        pc_src;
    logic        reg2loc;
    logic [1:0]  seu;
    logic        alu_src;
    logic [2:0]  alu_op;
    logic        mem_to_reg;
    logic        reg_wr;
    logic        instr_done;
    logic        err;
    logic [2:0]  state;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_rd, mem_wr, addr_sel, ir_wr, pc_wr, pc_src, reg2loc, seu, alu_src, alu_op,
               mem_to_reg, reg_wr, instr_done, err, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_rd, mem_wr, addr_sel, ir_wr, pc_wr, pc_src, reg2loc, seu, alu_src, alu_op,
               mem_to_reg, reg_wr, instr_done, err, state
    );
endinterface

// File: rtl/legv8_multicycle_ctrl.sv
// Multicycle LEGv8 sequencer: FETCH/DECODE/EXEC/MEM/WB/BRANCH over one shared memory port,
// with a bounded wait on mem_ready and a sticky error state.
module legv8_multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input logic                     i_clk,
    input logic                     i_rst,
    legv8_multicycle_ctrl_if.master io_ctrl
);
    localparam int unsigned CntW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    // Timeout fires on the MEM_TIMEOUT-th consecutive wait cycle.
    localparam logic [CntW-1:0] WaitLimit = CntW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StBranch = 3'd5,
        StErr    = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        ClsAdd, ClsSub, ClsAnd, ClsOrr, ClsAddi, ClsSubi, ClsAndi, ClsOrri,
        ClsLdur, ClsStur, ClsCbz, ClsCbnz, ClsB, ClsBad
    } cls_e;

    state_e          r_state, w_state_d;
    cls_e            r_cls, w_cls_d, w_dec_cls;
    logic [CntW-1:0] r_wait, w_wait_d;
    logic            w_mem_wait, w_timeout;
    logic            w_is_r, w_is_i, w_is_ls, w_take;
    logic [2:0]      w_alu_op;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StFetch;
            r_cls   <= ClsBad;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_d;
            r_cls   <= w_cls_d;
            r_wait  <= w_wait_d;
        end
    end

    // Widest pattern wins.
    always_comb begin
        w_dec_cls = ClsBad;
        if      (io_ctrl.opcode == 11'b10001011000)      w_dec_cls = ClsAdd;
        else if (io_ctrl.opcode == 11'b11001011000)      w_dec_cls = ClsSub;
        else if (io_ctrl.opcode == 11'b10001010000)      w_dec_cls = ClsAnd;
        else if (io_ctrl.opcode == 11'b10101010000)      w_dec_cls = ClsOrr;
        else if (io_ctrl.opcode == 11'b11111000010)      w_dec_cls = ClsLdur;
        else if (io_ctrl.opcode == 11'b11111000000)      w_dec_cls = ClsStur;
        else if (io_ctrl.opcode[10:1] == 10'b1001000100) w_dec_cls = ClsAddi;
        else if (io_ctrl.opcode[10:1] == 10'b1101000100) w_dec_cls = ClsSubi;
        else if (io_ctrl.opcode[10:1] == 10'b1001001000) w_dec_cls = ClsAndi;
        else if (io_ctrl.opcode[10:1] == 10'b1011001000) w_dec_cls = ClsOrri;
        else if (io_ctrl.opcode[10:3] == 8'b10110100)    w_dec_cls = ClsCbz;
        else if (io_ctrl.opcode[10:3] == 8'b10110101)    w_dec_cls = ClsCbnz;
        else if (io_ctrl.opcode[10:5] == 6'b000101)      w_dec_cls = ClsB;
    end

    always_comb begin
        w_is_r  = r_cls inside {ClsAdd, ClsSub, ClsAnd, ClsOrr};
        w_is_i  = r_cls inside {ClsAddi, ClsSubi, ClsAndi, ClsOrri};
        w_is_ls = r_cls inside {ClsLdur, ClsStur};
        w_take  = io_ctrl.zero ^ (r_cls == ClsCbnz);
        case (r_cls)
            ClsSub, ClsSubi: w_alu_op = 3'b001;
            ClsAnd, ClsAndi: w_alu_op = 3'b010;
            ClsOrr, ClsOrri: w_alu_op = 3'b011;
            default:         w_alu_op = 3'b000;
        endcase
    end

    always_comb begin
        w_state_d  = r_state;
        w_cls_d    = r_cls;
        w_mem_wait = ((r_state == StFetch) || (r_state == StMem)) && !io_ctrl.mem_ready;
        w_timeout  = (MEM_TIMEOUT != 0) && w_mem_wait && (r_wait == WaitLimit);
        w_wait_d   = w_mem_wait ? r_wait + 1'b1 : '0;
        case (r_state)
            StFetch: begin
                if (io_ctrl.mem_ready) w_state_d = StDecode;
                else if (w_timeout)    w_state_d = StErr;
            end
            StDecode: begin
                w_cls_d = w_dec_cls;
                case (w_dec_cls)
                    ClsCbz, ClsCbnz, ClsB: w_state_d = StBranch;
                    ClsBad:                w_state_d = StErr;
                    default:               w_state_d = StExec;
                endcase
            end
            StExec:   w_state_d = w_is_ls ? StMem : StWb;
            StMem: begin
                if (io_ctrl.mem_ready) w_state_d = (r_cls == ClsLdur) ? StWb : StFetch;
                else if (w_timeout)    w_state_d = StErr;
            end
            StWb, StBranch: w_state_d = StFetch;
            default:        w_state_d = StErr;
        endcase
    end

    always_comb begin
        io_ctrl.mem_rd     = 1'b0;
        io_ctrl.mem_wr     = 1'b0;
        io_ctrl.addr_sel   = 1'b0;
        io_ctrl.ir_wr      = 1'b0;
        io_ctrl.pc_wr      = 1'b0;
        io_ctrl.pc_src     = 1'b0;
        io_ctrl.reg2loc    = 1'b0;
        io_ctrl.seu        = 2'b00;
        io_ctrl.alu_src    = 1'b0;
        io_ctrl.alu_op     = 3'b000;
        io_ctrl.mem_to_reg = 1'b0;
        io_ctrl.reg_wr     = 1'b0;
        io_ctrl.instr_done = 1'b0;
        io_ctrl.err        = 1'b0;
        io_ctrl.state      = 3'd0;
        if (!i_rst) begin
            io_ctrl.state = r_state;
            // EXEC controls stay on through MEM/WB so the ALU result remains stable.
            if (r_state inside {StExec, StMem, StWb}) begin
                if (w_is_r || w_is_i) begin
                    io_ctrl.alu_src = w_is_i;
                    io_ctrl.alu_op  = w_alu_op;
                end else if (w_is_ls) begin
                    io_ctrl.seu     = 2'b01;
                    io_ctrl.alu_src = 1'b1;
                    io_ctrl.reg2loc = (r_cls == ClsStur);
                end
            end
            case (r_state)
                StFetch: begin
                    io_ctrl.mem_rd = 1'b1;
                    io_ctrl.ir_wr  = io_ctrl.mem_ready;
                    io_ctrl.pc_wr  = io_ctrl.mem_ready;
                end
                StMem: begin
                    io_ctrl.addr_sel = 1'b1;
                    if (r_cls == ClsLdur) begin
                        io_ctrl.mem_rd = 1'b1;
                    end else begin
                        io_ctrl.mem_wr     = 1'b1;
                        io_ctrl.reg2loc    = 1'b1;
                        io_ctrl.instr_done = io_ctrl.mem_ready;
                    end
                end
                StWb: begin
                    io_ctrl.reg_wr     = 1'b1;
                    io_ctrl.mem_to_reg = (r_cls == ClsLdur);
                    io_ctrl.instr_done = 1'b1;
                end
                StBranch: begin
                    io_ctrl.instr_done = 1'b1;
                    if (r_cls == ClsB) begin
                        io_ctrl.seu    = 2'b10;
                        io_ctrl.pc_src = 1'b1;
                        io_ctrl.pc_wr  = 1'b1;
                    end else begin
                        io_ctrl.seu     = 2'b11;
                        io_ctrl.reg2loc = 1'b1;
                        io_ctrl.alu_op  = 3'b100;
                        io_ctrl.pc_src  = w_take;
                        io_ctrl.pc_wr   = w_take;
                    end
                end
                StErr:   io_ctrl.err = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Scoreboard bench for legv8_multicycle_ctrl: directed cases plus random instructions checked
// against an opcode-table reference model.
module tb_legv8_multicycle_ctrl;
    localparam int TO = 4;

    typedef struct {
        bit         is_err;
        int         lat;
        bit         ex_chk;
        logic [2:0] ex_alu_op;
        logic       ex_alu_src;
        logic [1:0] ex_seu;
        logic       ex_reg2loc;
        logic       pc_wr;
        logic       pc_src;
        logic       reg_wr;
        logic       mem_to_reg;
        logic       mem_wr;
        bit         rt_chk;
        logic [1:0] rt_seu;
        logic [2:0] rt_alu_op;
        logic       rt_reg2loc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    legv8_multicycle_ctrl_if bus ();

    legv8_multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_ctrl(bus)
    );

    // ADD SUB AND ORR LDUR STUR ADDI SUBI ANDI ORRI CBZ CBNZ B, left-aligned with prefix width
    logic [10:0] pat_v [13] = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
                                11'b11111000010, 11'b11111000000, 11'b10010001000, 11'b11010001000,
                                11'b10010010000, 11'b10110010000, 11'b10110100000, 11'b10110101000,
                                11'b00010100000};
    int          pat_w [13] = '{11, 11, 11, 11, 11, 11, 10, 10, 10, 10, 8, 8, 6};

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   fetch_dly = 0;
    int   data_dly  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int classify(input logic [10:0] op);
        int best = -1;
        int bw   = 0;
        for (int i = 0; i < 13; i++) begin
            if (pat_w[i] > bw && (op >> (11 - pat_w[i])) == (pat_v[i] >> (11 - pat_w[i]))) begin
                best = i;
                bw   = pat_w[i];
            end
        end
        return best;
    endfunction

    function automatic exp_t model(input logic [10:0] op, input logic z, input int fd, input int dd);
        exp_t e;
        int   id;
        e  = '{default: 0};
        id = classify(op);
        if (id inside {[0:3], [6:9]}) begin
            e.ex_chk     = 1;
            e.ex_alu_op  = 3'((id < 4) ? id : id - 6);
            e.ex_alu_src = (id >= 6);
            e.reg_wr     = 1;
            e.lat        = 4 + fd;
        end else if (id == 4 || id == 5) begin
            e.ex_chk     = 1;
            e.ex_seu     = 2'b01;
            e.ex_alu_src = 1;
            e.ex_reg2loc = (id == 5);
            if (id == 4) begin
                e.reg_wr     = 1;
                e.mem_to_reg = 1;
                e.lat        = 5 + fd + dd;
            end else begin
                e.mem_wr     = 1;
                e.rt_chk     = 1;
                e.rt_seu     = 2'b01;
                e.rt_reg2loc = 1;
                e.lat        = 4 + fd + dd;
            end
        end else if (id == 10 || id == 11) begin
            e.rt_chk     = 1;
            e.rt_seu     = 2'b11;
            e.rt_alu_op  = 3'b100;
            e.rt_reg2loc = 1;
            e.pc_wr      = (id == 10) ? z : !z;
            e.pc_src     = e.pc_wr;
            e.lat        = 3 + fd;
        end else if (id == 12) begin
            e.rt_chk = 1;
            e.rt_seu = 2'b10;
            e.pc_wr  = 1;
            e.pc_src = 1;
            e.lat    = 3 + fd;
        end else begin
            e.is_err = 1;
            e.lat    = 3 + fd;
        end
        if (fd >= TO) begin
            e.is_err = 1;
            e.ex_chk = 0;
            e.lat    = TO + 1;
        end else if ((id == 4 || id == 5) && dd >= TO) begin
            e.is_err = 1;
            e.lat    = fd + TO + 4;
        end
        return e;
    endfunction

    // Memory responder: mem_ready after the programmed number of wait cycles per access.
    initial begin
        int wcnt = 0;
        bus.mem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                bus.mem_ready = 1'b0;
                wcnt = 0;
            end else begin
                if (bus.mem_ready) wcnt = 0;
                if (bus.mem_rd || bus.mem_wr) begin
                    bus.mem_ready = (wcnt >= (bus.addr_sel ? data_dly : fetch_dly));
                    wcnt++;
                end else begin
                    bus.mem_ready = 1'b0;
                    wcnt = 0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on each retire or error.
    int   cyc     = 0;
    bit   in_err  = 0;
    bit   post_rst = 0;
    exp_t me;
    always @(negedge clk) begin
        if (rst) begin
            cyc = 0;
            in_err = 0;
            post_rst = 1;
            chk("reset_zero", {bus.mem_rd, bus.mem_wr, bus.addr_sel, bus.ir_wr, bus.pc_wr,
                bus.pc_src, bus.reg2loc, bus.seu, bus.alu_src, bus.alu_op, bus.mem_to_reg,
                bus.reg_wr, bus.instr_done, bus.err, bus.state}, 0);
        end else begin
            cyc++;
            if (post_rst) begin
                chk("post_reset_fetch", {bus.mem_rd, bus.addr_sel, bus.state}, {1'b1, 1'b0, 3'd0});
                post_rst = 0;
            end
            if (in_err) begin
                chk("err_sticky", {bus.err, bus.mem_rd, bus.mem_wr, bus.reg_wr, bus.pc_wr,
                    bus.ir_wr, bus.instr_done}, 7'b1000000);
            end else if (bus.err) begin
                in_err = 1;
                chk("err_expected", q.size() > 0 ? q[0].is_err : 1'b0, 1);
                if (q.size() > 0) begin
                    me = q.pop_front();
                    chk("err_latency", cyc, me.lat);
                end
            end else begin
                if (bus.state == 3'd2 && q.size() > 0 && q[0].ex_chk)
                    chk("exec_ctrl", {bus.alu_op, bus.alu_src, bus.seu, bus.reg2loc, bus.reg_wr,
                        bus.mem_rd, bus.mem_wr}, {q[0].ex_alu_op, q[0].ex_alu_src, q[0].ex_seu,
                        q[0].ex_reg2loc, 3'b000});
                if (bus.instr_done) begin
                    chk("retire_expected", q.size(), q.size() > 0 ? q.size() : 1);
                    if (q.size() > 0) begin
                        me = q.pop_front();
                        chk("retire_kind", {bus.err, bus.instr_done}, me.is_err ? 2'b10 : 2'b01);
                        chk("retire_latency", cyc, me.lat);
                        chk("retire_ctrl", {bus.pc_wr, bus.pc_src, bus.reg_wr, bus.mem_to_reg,
                            bus.mem_wr}, {me.pc_wr, me.pc_src, me.reg_wr, me.mem_to_reg, me.mem_wr});
                        if (me.rt_chk)
                            chk("retire_dp", {bus.seu, bus.alu_op, bus.reg2loc},
                                {me.rt_seu, me.rt_alu_op, me.rt_reg2loc});
                    end
                    cyc = 0;
                end else begin
                    chk("no_stray_write", {bus.reg_wr, bus.mem_wr & bus.mem_ready}, 0);
                end
            end
        end
    end

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic issue(input logic [10:0] op, input logic z, input int fd, input int dd);
        exp_t e;
        int   n = 0;
        bus.opcode = op;
        bus.zero   = z;
        fetch_dly  = fd;
        data_dly   = dd;
        e = model(op, z, fd, dd);
        q.push_back(e);
        while (q.size() != 0 && n < 80) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drained", q.size(), 0);
        if (q.size() != 0) do_reset(2);
        else if (e.is_err) begin
            repeat (4) @(posedge clk);
            #1;
            do_reset(2);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got 1, expected 0");
        $fatal(1, "time limit");
    end

    initial begin
        logic [10:0] m;
        logic [10:0] op;
        int          k;
        int          n;
        bit          saw;
        bus.opcode = '0;
        bus.zero   = 1'b0;
        do_reset(2);

        issue(11'b10001011000, 1'b0, 0, 0);
        issue(11'b11111000010, 1'b0, 0, 3);
        issue(11'b10110100101, 1'b1, 0, 0);
        issue(11'b10110101011, 1'b1, 0, 0);
        issue(11'b00010111111, 1'b0, 0, 0);
        issue(11'b00010100000, 1'b1, 2, 0);
        issue(11'b11111000000, 1'b0, 1, 2);
        issue(11'b10010001001, 1'b0, 0, 0);
        issue(11'h000, 1'b0, 0, 0);
        issue(11'b10001011000, 1'b0, 100, 0);
        issue(11'b11111000010, 1'b0, 0, 100);

        // STUR with memory stalled, reset in the middle of the data phase.
        bus.opcode = 11'b11111000000;
        fetch_dly  = 0;
        data_dly   = 100;
        saw = 0;
        n = 0;
        while (!saw && n < 20) begin
            @(posedge clk);
            #1;
            saw = bus.mem_wr;
            n++;
        end
        chk("stur_mem_wr_seen", saw, 1);
        do_reset(2);

        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                op = 11'($urandom);
            end else begin
                k  = $urandom_range(0, 12);
                m  = 11'((1 << (11 - pat_w[k])) - 1);
                op = pat_v[k] | (11'($urandom) & m);
            end
            issue(op, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        chk("queue_empty_end", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
